// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, word/round-key types, FSM states and helpers
package aes_pkg;
   localparam int AES_NB = 4;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] rkey_t;
   typedef enum logic {IDLE, RUN} state_t;
   function automatic int nk_of(input int key_bits);
      return key_bits / 32;
   endfunction
   function automatic int nr_of(input int key_bits);
      return key_bits / 32 + 6;
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
//   x in 8 : byte to substitute
//   y out 8: S(x)
module aes_sbox (
   input  logic [7:0] x,
   output logic [7:0] y
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   // entry 0 sits in the top byte, so the bit offset is (255-x)*8
   assign y = SBOX[{~x, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: sequential AES key schedule, one 32-bit word per cycle,
// streaming round keys 0..Nr over a valid/ready handshake.
//   clk, rst (async, active high); start/cipher_key: load a new key while idle
//   busy: schedule in progress; rk_valid/rk_ready: round-key handshake
//   rk_data/rk_round/rk_last: round key, its index, final-round flag
//   Optional macro AES_KEY_CACHE_EN adds a 15-entry round-key store with
//   rd_round (in) / rd_key (out, 1-cycle latency) and cache_full (out).
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_BITS-1:0] cipher_key,
   output logic                busy,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [127:0]        rk_data,
   output logic [3:0]          rk_round,
`ifdef AES_KEY_CACHE_EN
   input  logic [3:0]          rd_round,
   output logic [127:0]        rd_key,
   output logic                cache_full,
`endif
   output logic                rk_last
);
   localparam int NK = nk_of(KEY_BITS);
   localparam int NR = nr_of(KEY_BITS);
   localparam int TOTAL = AES_NB * (NR + 1);
   state_t state, state_nx;
   // 8-word ring indexed by word number mod 8; holds both the unreleased
   // round-key words and the w[i-Nk] history the recurrence needs
   word_t wbuf [8];
   logic [5:0] i, occ;
   logic [2:0] k;
   logic [3:0] r;
   logic [7:0] rcon;
   logic accept, gen, last, rot_case, sub_case;
   word_t w_nk, w_prev, sub_in, sub_out, w_new;
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (.x(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
   end
   always_comb begin
      w_nk = wbuf[i[2:0] - 3'(NK)];
      w_prev = wbuf[i[2:0] - 3'd1];
      rot_case = k == 3'd0;
      sub_case = (NK == 8) && (k == 3'd4);
      sub_in = rot_case ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      w_new = w_nk ^ (rot_case ? sub_out ^ {rcon, 24'h0} : sub_case ? sub_out : w_prev);
      occ = i - {r, 2'b00};
      last = r == 4'(NR);
      accept = rk_valid && rk_ready;
      // a same-cycle accept frees the slot that the new word overwrites
      gen = (state == RUN) && (i < 6'(TOTAL)) && ((occ < 6'd8) || accept);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (state == IDLE && start) state_nx = RUN;
      else if (state == RUN && accept && last) state_nx = IDLE;
   end
   always_comb begin
      busy = state == RUN;
      rk_valid = busy && (occ >= 6'd4);
      rk_last = rk_valid && last;
      rk_round = r;
      rk_data = {wbuf[{r[0], 2'd0}], wbuf[{r[0], 2'd1}], wbuf[{r[0], 2'd2}], wbuf[{r[0], 2'd3}]};
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int j = 0; j < 8; j++) wbuf[j] <= '0;
         i <= '0;
         k <= '0;
         r <= '0;
         rcon <= '0;
      end else if (state == IDLE && start) begin
         for (int j = 0; j < NK; j++) wbuf[j] <= cipher_key[KEY_BITS-1-32*j -: 32];
         i <= 6'(NK);
         k <= '0;
         r <= '0;
         rcon <= 8'h01;
      end else begin
         if (gen) begin
            wbuf[i[2:0]] <= w_new;
            i <= i + 6'd1;
            k <= (k == 3'(NK - 1)) ? 3'd0 : k + 3'd1;
            if (rot_case) rcon <= xtime(rcon);
         end
         if (accept && !last) r <= r + 4'd1;
      end
`ifdef AES_KEY_CACHE_EN
   rkey_t store [15];
   always_ff @(posedge clk)
      if (rk_valid) store[r] <= rk_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_key <= '0;
         cache_full <= 1'b0;
      end else begin
         rd_key <= (rd_round < 4'd15) ? store[rd_round] : '0;
         if (state == IDLE && start) cache_full <= 1'b0;
         else if (rk_valid && last) cache_full <= 1'b1;
      end
`endif
endmodule
